lsu_warp: RTL

Multi-thread load/store unit serving the THREADS lanes of one warp over a single data-memory channel. It accepts one warp-wide LDR or STR with a per-thread active mask and serialises the active lanes onto the memory read or write handshake in ascending lane order. It collects load results per lane and signals completion once for the whole warp. It sits between the per-core register files and the data memory controller, and replaces per-thread LSU instances that each own a channel.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_warp_if.sv | 28 ++
 rtl/lsu_lane_select.sv | 26 ++
 rtl/lsu_warp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the warp load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int lane_bits(input int threads);
    if (threads > 1) begin
      return $clog2(threads);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/lsu_warp_if.sv
// Single data-memory channel shared by all lanes of a warp.
interface lsu_warp_if #(
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8
);
  logic                          data_mem_read_valid;
  logic [DATA_MEM_ADDR_BITS-1:0] data_mem_read_address;
  logic                          data_mem_read_ready;
  logic [DATA_MEM_DATA_BITS-1:0] data_mem_read_data;
  logic                          data_mem_write_valid;
  logic [DATA_MEM_ADDR_BITS-1:0] data_mem_write_address;
  logic [DATA_MEM_DATA_BITS-1:0] data_mem_write_data;
  logic                          data_mem_write_ready;

  modport master (
    output data_mem_read_valid, data_mem_read_address,
    input  data_mem_read_ready, data_mem_read_data,
    output data_mem_write_valid, data_mem_write_address, data_mem_write_data,
    input  data_mem_write_ready
  );

  modport slave (
    input  data_mem_read_valid, data_mem_read_address,
    output data_mem_read_ready, data_mem_read_data,
    input  data_mem_write_valid, data_mem_write_address, data_mem_write_data,
    output data_mem_write_ready
  );
endinterface

// File: rtl/lsu_lane_select.sv
// Finds the lowest set bit of a lane mask.
module lsu_lane_select
  import lsu_pkg::*;
#(
  parameter  int THREADS   = 4,
  localparam int LANE_BITS = lane_bits(THREADS)
) (
  input  logic [THREADS-1:0]   mask,
  output logic [LANE_BITS-1:0] idx,
  output logic                 any
);

  // Scan from the top so the lowest set lane is the last one written.
  always_comb begin
    idx = {LANE_BITS{1'b0}};
    any = |mask;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = LANE_BITS'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/lsu_warp.sv
// Warp-wide load/store unit: serialises active lanes onto one memory channel
// in ascending lane order and pulses lsu_done once per warp request.
module lsu_warp
  import lsu_pkg::*;
#(
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int THREADS            = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load_enable,
  input  logic                                 store_enable,
  input  logic [THREADS-1:0]                   thread_mask,
  input  logic [THREADS*DATA_MEM_ADDR_BITS-1:0] address,
  input  logic [THREADS*DATA_MEM_DATA_BITS-1:0] store_data,
  output logic [THREADS*DATA_MEM_DATA_BITS-1:0] load_data,
  output logic                                 lsu_busy,
  output logic                                 lsu_done,
  lsu_warp_if.master                           mem
);

  localparam int A         = DATA_MEM_ADDR_BITS;
  localparam int D         = DATA_MEM_DATA_BITS;
  localparam int LANE_BITS = lane_bits(THREADS);

  state_t                 state_r, state_nxt_s;
  logic [THREADS-1:0]     pending_r, pending_nxt_s, cur_bit_s, sel_mask_s;
  logic [THREADS*A-1:0]   addr_r, addr_nxt_s;
  logic [THREADS*D-1:0]   sdata_r, sdata_nxt_s, load_data_r, load_data_nxt_s;
  logic [LANE_BITS-1:0]   lane_r, lane_nxt_s, sel_idx_s;
  logic                   sel_any_s, start_s, rd_xfer_s, wr_xfer_s;
  logic                   rvalid_r, rvalid_nxt_s, wvalid_r, wvalid_nxt_s;
  logic [A-1:0]           raddr_r, raddr_nxt_s, waddr_r, waddr_nxt_s;
  logic [D-1:0]           wdata_r, wdata_nxt_s;
  logic                   busy_r, done_r;

  assign start_s   = load_enable | store_enable;
  assign rd_xfer_s = rvalid_r & mem.data_mem_read_ready;
  assign wr_xfer_s = wvalid_r & mem.data_mem_write_ready;
  assign cur_bit_s = THREADS'(1) << lane_r;

  // In IDLE pick from the incoming mask, otherwise from what is left after the current lane.
  always_comb begin
    if (state_r == IDLE) begin
      sel_mask_s = thread_mask;
    end else begin
      sel_mask_s = pending_r & ~cur_bit_s;
    end
  end

  lsu_lane_select #(.THREADS(THREADS)) u_sel (
    .mask (sel_mask_s),
    .idx  (sel_idx_s),
    .any  (sel_any_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_enable) begin
          state_nxt_s = sel_any_s ? LOAD : DONE;
        end else if (store_enable) begin
          state_nxt_s = sel_any_s ? STORE : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (rd_xfer_s && !sel_any_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      STORE: begin
        if (wr_xfer_s && !sel_any_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = STORE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the request latches and the registered memory-side outputs.
  always_comb begin
    pending_nxt_s   = pending_r;
    addr_nxt_s      = addr_r;
    sdata_nxt_s     = sdata_r;
    lane_nxt_s      = lane_r;
    load_data_nxt_s = load_data_r;
    rvalid_nxt_s    = rvalid_r;
    raddr_nxt_s     = raddr_r;
    wvalid_nxt_s    = wvalid_r;
    waddr_nxt_s     = waddr_r;
    wdata_nxt_s     = wdata_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          pending_nxt_s = thread_mask;
          addr_nxt_s    = address;
          sdata_nxt_s   = store_data;
          lane_nxt_s    = sel_idx_s;
          if (sel_any_s && load_enable) begin
            rvalid_nxt_s = 1'b1;
            raddr_nxt_s  = address[sel_idx_s*A +: A];
          end else if (sel_any_s) begin
            wvalid_nxt_s = 1'b1;
            waddr_nxt_s  = address[sel_idx_s*A +: A];
            wdata_nxt_s  = store_data[sel_idx_s*D +: D];
          end else begin
            rvalid_nxt_s = 1'b0;
            wvalid_nxt_s = 1'b0;
          end
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      LOAD: begin
        if (rd_xfer_s) begin
          load_data_nxt_s[lane_r*D +: D] = mem.data_mem_read_data;
          pending_nxt_s = pending_r & ~cur_bit_s;
          lane_nxt_s    = sel_idx_s;
          if (sel_any_s) begin
            raddr_nxt_s = addr_r[sel_idx_s*A +: A];
          end else begin
            rvalid_nxt_s = 1'b0;
          end
        end else begin
          rvalid_nxt_s = rvalid_r;
        end
      end
      STORE: begin
        if (wr_xfer_s) begin
          pending_nxt_s = pending_r & ~cur_bit_s;
          lane_nxt_s    = sel_idx_s;
          if (sel_any_s) begin
            waddr_nxt_s = addr_r[sel_idx_s*A +: A];
            wdata_nxt_s = sdata_r[sel_idx_s*D +: D];
          end else begin
            wvalid_nxt_s = 1'b0;
          end
        end else begin
          wvalid_nxt_s = wvalid_r;
        end
      end
      DONE:    pending_nxt_s = pending_r;
      default: pending_nxt_s = pending_r;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_r   <= {THREADS{1'b0}};
      addr_r      <= {(THREADS*A){1'b0}};
      sdata_r     <= {(THREADS*D){1'b0}};
      lane_r      <= {LANE_BITS{1'b0}};
      load_data_r <= {(THREADS*D){1'b0}};
      rvalid_r    <= 1'b0;
      raddr_r     <= {A{1'b0}};
      wvalid_r    <= 1'b0;
      waddr_r     <= {A{1'b0}};
      wdata_r     <= {D{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      pending_r   <= pending_nxt_s;
      addr_r      <= addr_nxt_s;
      sdata_r     <= sdata_nxt_s;
      lane_r      <= lane_nxt_s;
      load_data_r <= load_data_nxt_s;
      rvalid_r    <= rvalid_nxt_s;
      raddr_r     <= raddr_nxt_s;
      wvalid_r    <= wvalid_nxt_s;
      waddr_r     <= waddr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
    end
  end

  assign load_data                  = load_data_r;
  assign lsu_busy                   = busy_r;
  assign lsu_done                   = done_r;
  assign mem.data_mem_read_valid    = rvalid_r;
  assign mem.data_mem_read_address  = raddr_r;
  assign mem.data_mem_write_valid   = wvalid_r;
  assign mem.data_mem_write_address = waddr_r;
  assign mem.data_mem_write_data    = wdata_r;

endmodule
